onehot_walker: RTL and testbench
================================

# onehot_walker

Sequential one-hot driver: the output-side counterpart of the one-hot-to-code path that feeds `SevenSeg`. It accepts a target code 1..8 and walks a single lit bit across an 8-bit one-hot bus, one position per step period, toward the target. It signals completion with a pulse. It also exports the current code so the lab top can show it on a seven-segment digit.

## Interface
- `STEP_DIV`, default 4: clk cycles per walk step; legal range 1..65535.

- `clk`  input  1  system clock, rising edge
- `rst`  input  1  asynchronous reset, active-high
- `load`  input  1  start request, sampled on rising `clk`
- `din`  input  4  target code; 1..8 are valid, all other values mean blank (0)
- `dout`  output  8  one-hot bus; code k lights bit (8-k), so code 1 = 8'b10000000 and code 8 = 8'b00000001; code 0 = 8'b00000000
- `pos`  output  4  current code 0..8; always consistent with `dout`
- `busy`  output  1  high while a walk is in progress
- `done`  output  1  one-cycle completion pulse

## Operation
- Reset values: `dout` = 8'h00, `pos` = 0, `busy` = 0, `done` = 0, state = IDLE, prescaler = 0.
- `din` values 0 and 9..15 are treated as target 0.
- State IDLE, with `load` = 1:
  - Latch the target.
  - If target == `pos`: stay in IDLE and assert `done` for one cycle. `dout`, `pos` and `busy` are unchanged.
  - Otherwise: go to MOVE, set `busy` = 1 and clear the prescaler.
- State MOVE:
  - The prescaler counts 0..STEP_DIV-1.
  - At terminal count, `pos` steps by +1 if target > `pos`, or by -1 if target < `pos`, and the prescaler wraps to 0.
  - `dout` is decoded from `pos` and registered, updating on the same edge as `pos`.
  - `pos` stays within 0..8. Stepping up from 0 lights code 1; stepping down from 1 blanks the bus.
- Completion: on the step edge where the new `pos` equals the target, the block returns to IDLE. On that same edge `busy` goes to 0 and `done` goes to 1 for exactly one cycle.
- `load` while `busy` = 1 is ignored: the target is unchanged and there is no side effect.
- `load` in the cycle where `done` is high is accepted (`busy` is already 0) and starts a new walk from the current `pos`.
- Asserting `rst` mid-walk forces all outputs to their reset values immediately, with no clock edge needed. After reset is released, walks start from `pos` = 0.
- `done` is never high while `busy` is high.

## Timing
- Let N be the edge that samples `load`. Let d = |target − `pos`| at N.
- d = 0: `done` = 1 for the cycle following edge N; `busy` stays 0.
- d > 0:
  - `busy` = 1 from edge N.
  - Step i (for i = 1..d) lands at edge N + i·STEP_DIV.
  - `busy` falls and `done` pulses at edge N + d·STEP_DIV.
- Worst-case walk (0 to 8 or 8 to 0): 8·STEP_DIV cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: assert `rst` with no clock running → `dout` = 00, `pos` = 0, `busy` = 0, `done` = 0.
- STEP_DIV = 4, `pos` = 0, load `din` = 3 at edge N → `dout` = 80 at N+4, 40 at N+8, 20 at N+12; `busy` is 1 over N..N+12; `done` is 1 for exactly the cycle after N+12.
- From `pos` = 3, load `din` = 3 → `done` pulses after edge N; `busy` stays 0; `dout` stays 20.
- From `pos` = 3, load `din` = 12 (treated as 0) → `dout` = 40, 80, 00 at N+4, N+8, N+12; `pos` ends at 0; `done` pulses once.
- Walk from 0 to 8. Pulse `load` with `din` = 1 at N+5 → ignored, and the walk reaches `dout` = 01 at N+32. Pulse `load` with `din` = 5 during the `done` cycle → accepted; the walk steps down to 5 and `done` pulses 12 cycles later.
- Mid-walk (`pos` = 2 on the way to 6), assert `rst` asynchronously → outputs clear immediately. Release reset and load 1 → `dout` = 80 after 4 cycles, then `done`.

Source files
------------

// File: rtl/onehot_walker.sv
// onehot_walker
//   Walks a single lit bit across an 8-bit one-hot bus toward a target code.
//   The walk moves one position every STEP_DIV clocks. A one-cycle done pulse
//   marks arrival.
//
//   Parameters
//     STEP_DIV : clk cycles per walk step (1..65535)
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous reset, active-high
//     load : start request, sampled on rising clk (ignored while busy)
//     din  : target code; 1..8 are valid, anything else means blank (0)
//     dout : one-hot bus; code k lights bit (8-k), code 0 is all dark
//     pos  : current code 0..8, always consistent with dout
//     busy : high while a walk is in progress
//     done : one-cycle completion pulse
module onehot_walker #(
  parameter int unsigned STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] din,
  output logic [7:0] dout,
  output logic [3:0] pos,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] PRE_LAST = 16'(STEP_DIV - 1);

  typedef enum logic {
    IDLE,
    MOVE
  } state_t;

  state_t      state_q;
  logic [3:0]  tgt_q;
  logic [3:0]  pos_q;
  logic [7:0]  dout_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] pre_q;

  logic [3:0]  tgt_d;
  logic [3:0]  pos_d;

  function automatic logic [7:0] decode(input logic [3:0] p);
    logic [7:0] r;
    case (p)
      4'd1:    r = 8'h80;
      4'd2:    r = 8'h40;
      4'd3:    r = 8'h20;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h08;
      4'd6:    r = 8'h04;
      4'd7:    r = 8'h02;
      4'd8:    r = 8'h01;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Out-of-range codes blank the bus. Because the target is always 0..8,
  // a step toward it can never leave that range.
  always_comb begin
    tgt_d = '0;
    if (din >= 4'd1 && din <= 4'd8) begin
      tgt_d = din;
    end
    pos_d = (tgt_q > pos_q) ? pos_q + 4'd1 : pos_q - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      pos_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            tgt_q <= tgt_d;
            if (tgt_d == pos_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= MOVE;
              busy_q  <= 1'b1;
              pre_q   <= '0;
            end
          end
        end
        MOVE: begin
          if (pre_q == PRE_LAST) begin
            pre_q  <= '0;
            pos_q  <= pos_d;
            dout_q <= decode(pos_d);
            if (pos_d == tgt_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            pre_q <= pre_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = dout_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_onehot_walker.sv
module tb_onehot_walker;

  localparam int SD = 4;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       load;
  logic [3:0] din;
  logic [7:0] dout;
  logic [3:0] pos;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] dout;
    logic [3:0] pos;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  onehot_walker #(.STEP_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .dout (dout),
    .pos  (pos),
    .busy (busy),
    .done (done)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [7:0] onehot(input int p);
    logic [7:0] one;
    one = 8'h01;
    if (p == 0) return 8'h00;
    return one << (8 - p);
  endfunction

  // Expected samples taken #1 after each edge, starting at the load edge N.
  // Step i lands at N + i*SD; done pulses after N + d*SD.
  task automatic expect_walk(input int start, input int tgt, input bit tail);
    exp_t e;
    int d;
    int p;
    d = (tgt > start) ? tgt - start : start - tgt;
    if (d == 0) begin
      e = '{onehot(start), 4'(start), 1'b0, 1'b1};
      q.push_back(e);
    end else begin
      for (int k = 0; k <= d * SD; k++) begin
        if (k == d * SD) begin
          e = '{onehot(tgt), 4'(tgt), 1'b0, 1'b1};
        end else begin
          p = (tgt > start) ? start + k / SD : start - k / SD;
          e = '{onehot(p), 4'(p), 1'b1, 1'b0};
        end
        q.push_back(e);
      end
    end
    if (tail) begin
      e = '{onehot(tgt), 4'(tgt), 1'b0, 1'b0};
      q.push_back(e);
    end
  endtask

  task automatic cycle(input logic ld, input logic [3:0] d);
    @(negedge clk);
    load = ld;
    din  = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, pos, busy, done} !== 14'h0) begin
      failures++;
      $display("FAIL reset dout=%h pos=%0d busy=%b done=%b expected all zero",
               dout, pos, busy, done);
    end
    #5;
    rst = 1'b0;
    clk_en = 1'b1;
    cycle(1'b0, 4'd0);
    checks++;
    if ({dout, pos, busy, done} !== 14'h0) begin
      failures++;
      $display("FAIL reset_idle dout=%h pos=%0d busy=%b done=%b expected all zero",
               dout, pos, busy, done);
    end
  endtask

  task automatic test_walk_up;
    exp_t e;
    int c;
    expect_walk(0, 3, 1'b1);
    c = 0;
    while (q.size() > 0 && c < 200) begin
      cycle(c == 0, 4'd3);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL walk_up c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      c++;
    end
  endtask

  task automatic test_same_target;
    exp_t e;
    int c;
    expect_walk(3, 3, 1'b1);
    c = 0;
    while (q.size() > 0 && c < 200) begin
      cycle(c == 0, 4'd3);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL same_target c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      c++;
    end
  endtask

  task automatic test_blank_target;
    exp_t e;
    int c;
    expect_walk(3, 0, 1'b1);
    c = 0;
    while (q.size() > 0 && c < 200) begin
      cycle(c == 0, 4'd12);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL blank_target c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      c++;
    end
  endtask

  // 0 -> 8 with an ignored load at N+5, then a load during the done cycle
  // (sampled at N+33) that walks back down to 5.
  task automatic test_back_to_back;
    exp_t e;
    int c;
    logic ld;
    logic [3:0] d;
    expect_walk(0, 8, 1'b0);
    expect_walk(8, 5, 1'b1);
    c = 0;
    while (q.size() > 0 && c < 200) begin
      ld = (c == 0 || c == 5 || c == 33);
      d  = (c == 0) ? 4'd8 : (c == 5) ? 4'd1 : 4'd5;
      cycle(ld, d);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL back_to_back c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      checks++;
      if (done === 1'b1 && busy === 1'b1) begin
        failures++;
        $display("FAIL done_busy_overlap c=%0d done=%b busy=%b expected not both high",
                 c, done, busy);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid_walk;
    exp_t e;
    int c;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_walk(0, 6, 1'b0);
    c = 0;
    while (c < 10) begin
      cycle(c == 0, 4'd6);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL mid_walk c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      c++;
    end
    q.delete();
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, pos, busy, done} !== 14'h0) begin
      failures++;
      $display("FAIL async_reset dout=%h pos=%0d busy=%b done=%b expected all zero",
               dout, pos, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    expect_walk(0, 1, 1'b1);
    c = 0;
    while (q.size() > 0 && c < 200) begin
      cycle(c == 0, 4'd1);
      e = q.pop_front();
      checks++;
      if ({dout, pos, busy, done} !== {e.dout, e.pos, e.busy, e.done}) begin
        failures++;
        $display("FAIL after_reset c=%0d dout=%h pos=%0d busy=%b done=%b expected dout=%h pos=%0d busy=%b done=%b",
                 c, dout, pos, busy, done, e.dout, e.pos, e.busy, e.done);
      end
      c++;
    end
  endtask

  initial begin
    clk      = 1'b0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    load     = 1'b0;
    din      = 4'd0;
    checks   = 0;
    failures = 0;
    test_reset;
    test_walk_up;
    test_same_target;
    test_blank_target;
    test_back_to_back;
    test_reset_mid_walk;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
